// File: rtl/activation_buffer_read_arbiter.sv
// Read arbiter: N stream readers plus one AXI word reader over 2N
// ping-pong line buffers, with tagged return pipeline.
module activation_buffer_read_arbiter #(
  parameter int NUM_STREAMS  = 3,
  parameter int BANK_COUNT   = 4,
  parameter int BANK_WIDTH   = 64,
  parameter int LB_DEPTH     = 512,
  parameter int RAM_LATENCY  = 1,
  parameter int AXI_MAX_WAIT = 4,
  localparam int NUM_LB = 2 * NUM_STREAMS,
  localparam int AW     = $clog2(LB_DEPTH),
  localparam int LBW    = $clog2(NUM_LB),
  localparam int BSW    = $clog2(BANK_COUNT),
  localparam int AXW    = LBW + AW + BSW,
  localparam int WORD   = BANK_COUNT * BANK_WIDTH
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_STREAMS-1:0]      i_stream_req_valid,
  input  logic [NUM_STREAMS*AW-1:0]   i_stream_addr,
  input  logic [NUM_STREAMS-1:0]      i_stream_ping_pong,
  output logic [NUM_STREAMS-1:0]      o_stream_req_ready,
  output logic [NUM_STREAMS-1:0]      o_stream_data_valid,
  output logic [NUM_STREAMS*WORD-1:0] o_stream_data,
  input  logic                        i_axi_req_valid,
  input  logic [AXW-1:0]              i_axi_word_addr,
  output logic                        o_axi_req_ready,
  output logic                        o_axi_rdata_valid,
  output logic [BANK_WIDTH-1:0]       o_axi_rdata,
  output logic                        o_axi_rd_error,
  output logic [NUM_LB-1:0]           o_buf_rd_en,
  output logic [NUM_LB*AW-1:0]        o_buf_addr,
  input  logic [NUM_LB*WORD-1:0]      i_buf_rdata,
  output logic [15:0]                 o_conflict_count
);

  localparam int WW = $clog2(AXI_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(AXI_MAX_WAIT);
  localparam int LL = RAM_LATENCY - 1;

  logic [WW-1:0] wait_q, wait_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [NUM_STREAMS-1:0][LBW-1:0] own;
  logic [NUM_STREAMS-1:0]          hit, s_gnt;
  logic [LBW-1:0] a_lb;
  logic [AW-1:0]  a_line;
  logic [BSW-1:0] a_bank;
  logic a_inr, conflict, a_win, a_gnt;

  logic [RAM_LATENCY-1:0][NUM_STREAMS-1:0]          sv_q;
  logic [RAM_LATENCY-1:0][NUM_STREAMS-1:0][LBW-1:0] slb_q;
  logic [RAM_LATENCY-1:0]                           av_q, aerr_q;
  logic [RAM_LATENCY-1:0][LBW-1:0]                  alb_q;
  logic [RAM_LATENCY-1:0][BSW-1:0]                  abk_q;

  // Ownership, conflict detection and grants
  always_comb begin
    a_lb   = i_axi_word_addr[AXW-1 -: LBW];
    a_line = i_axi_word_addr[BSW +: AW];
    a_bank = i_axi_word_addr[BSW-1:0];
    a_inr  = int'(a_lb) < NUM_LB;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      own[i] = LBW'(i + (i_stream_ping_pong[i] ? NUM_STREAMS : 0));
      hit[i] = i_stream_req_valid[i] & i_axi_req_valid
             & a_inr & (own[i] == a_lb);
    end
    conflict = |hit;
    a_win    = (wait_q == WMAX);
    a_gnt    = i_axi_req_valid & (~conflict | a_win);
    s_gnt    = i_stream_req_valid & ~(hit & {NUM_STREAMS{a_win}});
  end

  // Line-buffer port steering; unused ports stay idle at address 0
  always_comb begin
    o_buf_rd_en = '0;
    o_buf_addr  = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (s_gnt[i]) begin
        o_buf_rd_en[own[i]] = 1'b1;
        o_buf_addr[own[i]*AW +: AW] = i_stream_addr[i*AW +: AW];
      end
    end
    if (a_gnt && a_inr) begin
      o_buf_rd_en[a_lb] = 1'b1;
      o_buf_addr[a_lb*AW +: AW] = a_line;
    end
  end

  // Bounded-wait counter and saturating stall counter
  always_comb begin
    wait_d = '0;
    cnt_d  = cnt_q;
    if (conflict && !a_win) begin
      wait_d = wait_q + 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  // Arbitration state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
    end
  end

  // Return tag pipeline, one stage per cycle of RAM latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sv_q   <= '0;
      slb_q  <= '0;
      av_q   <= '0;
      aerr_q <= '0;
      alb_q  <= '0;
      abk_q  <= '0;
    end else begin
      sv_q[0]   <= s_gnt;
      slb_q[0]  <= own;
      av_q[0]   <= a_gnt;
      aerr_q[0] <= a_gnt & ~a_inr;
      alb_q[0]  <= a_lb;
      abk_q[0]  <= a_bank;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        sv_q[k]   <= sv_q[k-1];
        slb_q[k]  <= slb_q[k-1];
        av_q[k]   <= av_q[k-1];
        aerr_q[k] <= aerr_q[k-1];
        alb_q[k]  <= alb_q[k-1];
        abk_q[k]  <= abk_q[k-1];
      end
    end
  end

  // Return muxes select by the tag captured at request time
  always_comb begin
    o_stream_data_valid = sv_q[LL];
    o_stream_data       = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (sv_q[LL][i])
        o_stream_data[i*WORD +: WORD] =
          i_buf_rdata[slb_q[LL][i]*WORD +: WORD];
    end
    o_axi_rdata_valid = av_q[LL];
    o_axi_rd_error    = av_q[LL] & aerr_q[LL];
    o_axi_rdata       = '0;
    if (av_q[LL] && !aerr_q[LL])
      o_axi_rdata = i_buf_rdata[alb_q[LL]*WORD
        + (BANK_COUNT-1-int'(abk_q[LL]))*BANK_WIDTH +: BANK_WIDTH];
  end

  assign o_stream_req_ready = s_gnt;
  assign o_axi_req_ready    = a_gnt;
  assign o_conflict_count   = cnt_q;

endmodule

// File: tb/tb_activation_buffer_read_arbiter.sv
// Testbench for activation_buffer_read_arbiter: directed scenarios
// plus randomized traffic against a cycle-level reference model.
module tb_activation_buffer_read_arbiter;

  localparam int N    = 3;
  localparam int BC   = 4;
  localparam int BWD  = 64;
  localparam int DEP  = 512;
  localparam int L    = 2;
  localparam int MW   = 4;
  localparam int NLB  = 2 * N;
  localparam int AW   = 9;
  localparam int BSW  = 2;
  localparam int AXW  = 3 + AW + BSW;
  localparam int WORD = BC * BWD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic [N-1:0]       s_valid, s_pp, s_ready, s_dvalid;
  logic [N*AW-1:0]    s_addr;
  logic [N*WORD-1:0]  s_data;
  logic               a_valid, a_ready, a_rvalid, a_err;
  logic [AXW-1:0]     a_addr;
  logic [BWD-1:0]     a_rdata;
  logic [NLB-1:0]     b_en;
  logic [NLB*AW-1:0]  b_addr;
  logic [NLB*WORD-1:0] b_rdata;
  logic [15:0]        ccount;

  logic [N-1:0]       e_sv, e_pp, e_sr, e_sdv;
  logic [N*AW-1:0]    e_sa;
  logic [N*WORD-1:0]  e_sd;
  logic               e_av, e_ar, e_arv, e_aerr;
  logic [AXW-1:0]     e_aa;
  logic [BWD-1:0]     e_ard;
  logic [NLB-1:0]     e_en;
  logic [NLB*AW-1:0]  e_ba;
  logic [NLB*WORD-1:0] e_brd;
  logic [15:0]        e_cc;

  logic [WORD-1:0] mem_w [NLB];
  int checks = 0;
  int errors = 0;

  activation_buffer_read_arbiter #(
    .NUM_STREAMS(N), .BANK_COUNT(BC), .BANK_WIDTH(BWD),
    .LB_DEPTH(DEP), .RAM_LATENCY(L), .AXI_MAX_WAIT(MW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_stream_req_valid(s_valid), .i_stream_addr(s_addr),
    .i_stream_ping_pong(s_pp), .o_stream_req_ready(s_ready),
    .o_stream_data_valid(s_dvalid), .o_stream_data(s_data),
    .i_axi_req_valid(a_valid), .i_axi_word_addr(a_addr),
    .o_axi_req_ready(a_ready), .o_axi_rdata_valid(a_rvalid),
    .o_axi_rdata(a_rdata), .o_axi_rd_error(a_err),
    .o_buf_rd_en(b_en), .o_buf_addr(b_addr),
    .i_buf_rdata(b_rdata), .o_conflict_count(ccount)
  );

  activation_buffer_read_arbiter #(
    .NUM_STREAMS(N), .BANK_COUNT(BC), .BANK_WIDTH(BWD),
    .LB_DEPTH(DEP), .RAM_LATENCY(L), .AXI_MAX_WAIT(100000)
  ) dut_sat (
    .clk(clk), .resetn(resetn),
    .i_stream_req_valid(e_sv), .i_stream_addr(e_sa),
    .i_stream_ping_pong(e_pp), .o_stream_req_ready(e_sr),
    .o_stream_data_valid(e_sdv), .o_stream_data(e_sd),
    .i_axi_req_valid(e_av), .i_axi_word_addr(e_aa),
    .o_axi_req_ready(e_ar), .o_axi_rdata_valid(e_arv),
    .o_axi_rdata(e_ard), .o_axi_rd_error(e_aerr),
    .o_buf_rd_en(e_en), .o_buf_addr(e_ba),
    .i_buf_rdata(e_brd), .o_conflict_count(e_cc)
  );

  task automatic new_mem();
    for (int l = 0; l < NLB; l++) begin
      for (int j = 0; j < WORD / 32; j++) mem_w[l][j*32 +: 32] = $urandom;
      b_rdata[l*WORD +: WORD] = mem_w[l];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    new_mem();
  endtask

  task automatic idle_inputs();
    s_valid = '0; s_pp = '0; s_addr = '0;
    a_valid = 1'b0; a_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #4;
    checks++;
    if (s_dvalid !== '0 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got s=%b a=%b exp 0", s_dvalid, a_rvalid);
    end
    checks++;
    if (s_data !== '0 || a_rdata !== '0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got nonzero data/err exp 0");
    end
    checks++;
    if (ccount !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", ccount);
    end
    checks++;
    if (b_en !== '0 || b_addr !== '0) begin
      errors++;
      $display("FAIL reset_buf got en=%b addr=%h exp 0", b_en, b_addr);
    end
  endtask

  task automatic test_parallel();
    logic [WORD-1:0] w;
    do_reset();
    s_valid[0] = 1'b1;
    s_addr[0 +: AW] = 9'd5;
    a_valid = 1'b1;
    a_addr = {3'd4, 9'd7, 2'd2};
    #4;
    checks++;
    if (s_ready[0] !== 1'b1 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL par_ready got s=%b a=%b exp 1 1", s_ready[0], a_ready);
    end
    checks++;
    if (b_en !== 6'b010001) begin
      errors++;
      $display("FAIL par_rden got %b exp 010001", b_en);
    end
    checks++;
    if (b_addr[0 +: AW] !== 9'd5 || b_addr[4*AW +: AW] !== 9'd7) begin
      errors++;
      $display("FAIL par_addr got %h exp lb0=5 lb4=7", b_addr);
    end
    step();
    idle_inputs();
    #4;
    checks++;
    if (s_dvalid !== '0 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL par_early got s=%b a=%b exp 0", s_dvalid, a_rvalid);
    end
    step();
    #4;
    w = mem_w[4];
    checks++;
    if (s_dvalid !== 3'b001 || s_data[0 +: WORD] !== mem_w[0]) begin
      errors++;
      $display("FAIL par_sdata got v=%b d=%h exp v=001 d=%h",
               s_dvalid, s_data[0 +: WORD], mem_w[0]);
    end
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== w[127:64] || a_err !== 1'b0) begin
      errors++;
      $display("FAIL par_axi got v=%b d=%h e=%b exp 1 %h 0",
               a_rvalid, a_rdata, a_err, w[127:64]);
    end
    step();
    #4;
    checks++;
    if (s_dvalid !== '0 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL par_oneshot got s=%b a=%b exp 0", s_dvalid, a_rvalid);
    end
  endtask

  task automatic test_conflict();
    bit exp_axi;
    do_reset();
    s_valid[1] = 1'b1;
    s_pp[1] = 1'b1;
    s_addr[AW +: AW] = 9'd100;
    a_valid = 1'b1;
    a_addr = {3'd4, 9'd33, 2'd1};
    for (int k = 0; k < 10; k++) begin
      exp_axi = (k == 4 || k == 9);
      #4;
      checks++;
      if (a_ready !== exp_axi || s_ready[1] !== !exp_axi) begin
        errors++;
        $display("FAIL conf_ready k=%0d got a=%b s1=%b exp a=%b s1=%b",
                 k, a_ready, s_ready[1], exp_axi, !exp_axi);
      end
      checks++;
      if (b_en !== 6'b010000 ||
          b_addr[4*AW +: AW] !== (exp_axi ? 9'd33 : 9'd100)) begin
        errors++;
        $display("FAIL conf_buf k=%0d got en=%b a4=%0d", k, b_en,
                 b_addr[4*AW +: AW]);
      end
      if (k == 4) begin
        checks++;
        if (ccount !== 16'd4) begin
          errors++;
          $display("FAIL conf_count4 got %0d exp 4", ccount);
        end
      end
      step();
    end
    idle_inputs();
    #4;
    checks++;
    if (ccount !== 16'd8) begin
      errors++;
      $display("FAIL conf_count8 got %0d exp 8", ccount);
    end
  endtask

  task automatic test_swap();
    do_reset();
    s_valid[2] = 1'b1;
    s_pp[2] = 1'b0;
    s_addr[2*AW +: AW] = 9'd11;
    #4;
    checks++;
    if (b_en !== 6'b000100 || b_addr[2*AW +: AW] !== 9'd11) begin
      errors++;
      $display("FAIL swap_ping got en=%b exp 000100", b_en);
    end
    step();
    s_pp[2] = 1'b1;
    s_addr[2*AW +: AW] = 9'd22;
    #4;
    checks++;
    if (b_en !== 6'b100000 || b_addr[5*AW +: AW] !== 9'd22) begin
      errors++;
      $display("FAIL swap_pong got en=%b exp 100000", b_en);
    end
    step();
    s_valid[2] = 1'b0;
    s_pp[2] = 1'b0;
    #4;
    checks++;
    if (s_dvalid !== 3'b100 || s_data[2*WORD +: WORD] !== mem_w[2]) begin
      errors++;
      $display("FAIL swap_ret1 got v=%b exp 100 from lb2", s_dvalid);
    end
    step();
    #4;
    checks++;
    if (s_dvalid !== 3'b100 || s_data[2*WORD +: WORD] !== mem_w[5]) begin
      errors++;
      $display("FAIL swap_ret2 got v=%b exp 100 from lb5", s_dvalid);
    end
  endtask

  task automatic test_oob();
    do_reset();
    a_valid = 1'b1;
    a_addr = {3'd7, 9'd3, 2'd0};
    #4;
    checks++;
    if (a_ready !== 1'b1 || b_en !== '0) begin
      errors++;
      $display("FAIL oob_req got rdy=%b en=%b exp 1 0", a_ready, b_en);
    end
    step();
    idle_inputs();
    step();
    #4;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== '0 || a_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_ret got v=%b d=%h e=%b exp 1 0 1",
               a_rvalid, a_rdata, a_err);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    s_valid = 3'b011;
    s_pp = 3'b010;
    a_valid = 1'b1;
    a_addr = {3'd4, 9'd1, 2'd0};
    step();
    idle_inputs();
    #4;
    checks++;
    if (ccount !== 16'd1) begin
      errors++;
      $display("FAIL rst_pre_count got %0d exp 1", ccount);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (s_dvalid !== '0 || a_rvalid !== 1'b0 || ccount !== 16'd0 ||
        s_data !== '0) begin
      errors++;
      $display("FAIL rst_async got s=%b a=%b cnt=%0d exp 0",
               s_dvalid, a_rvalid, ccount);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      #4;
      checks++;
      if (s_dvalid !== '0 || a_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_after k=%0d got s=%b a=%b exp 0",
                 k, s_dvalid, a_rvalid);
      end
    end
  endtask

  task automatic test_random(int ncyc);
    int m_wait, m_cnt, alb, aline, abk;
    int own [N];
    bit ds_v [8][N];
    int ds_lb [8][N];
    bit da_v [8];
    bit da_err [8];
    int da_lb [8];
    int da_bk [8];
    bit conf, awin, agnt;
    logic [N-1:0] x_sr, x_sdv;
    logic x_arv, x_aerr;
    logic [NLB-1:0] x_en;
    logic [NLB*AW-1:0] x_ba;
    logic [N*WORD-1:0] x_sd;
    logic [BWD-1:0] x_ard;
    int cur, fut;
    do_reset();
    m_wait = 0; m_cnt = 0; alb = 0;
    for (int s = 0; s < 8; s++) begin
      da_v[s] = 0;
      for (int i = 0; i < N; i++) ds_v[s][i] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) s_pp[i] = ~s_pp[i];
        s_addr[i*AW +: AW] = AW'($urandom_range(0, DEP - 1));
      end
      a_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) alb = $urandom_range(0, 7);
      aline = $urandom_range(0, DEP - 1);
      abk = $urandom_range(0, BC - 1);
      a_addr = {3'(alb), 9'(aline), 2'(abk)};
      conf = 0;
      for (int i = 0; i < N; i++) begin
        own[i] = i + (s_pp[i] ? N : 0);
        if (a_valid && alb < NLB && s_valid[i] && own[i] == alb) conf = 1;
      end
      awin = conf && (m_wait >= MW);
      agnt = a_valid && (!conf || awin);
      x_en = '0; x_ba = '0;
      for (int i = 0; i < N; i++) begin
        x_sr[i] = s_valid[i] && !(awin && own[i] == alb);
        if (x_sr[i]) begin
          x_en[own[i]] = 1'b1;
          x_ba[own[i]*AW +: AW] = s_addr[i*AW +: AW];
        end
      end
      if (agnt && alb < NLB) begin
        x_en[alb] = 1'b1;
        x_ba[alb*AW +: AW] = AW'(aline);
      end
      cur = c % 8;
      x_sd = '0;
      for (int i = 0; i < N; i++) begin
        x_sdv[i] = ds_v[cur][i];
        if (ds_v[cur][i]) x_sd[i*WORD +: WORD] = mem_w[ds_lb[cur][i]];
      end
      x_arv = da_v[cur];
      x_aerr = da_v[cur] && da_err[cur];
      x_ard = '0;
      if (da_v[cur] && !da_err[cur])
        x_ard = BWD'(mem_w[da_lb[cur]] >> ((BC - 1 - da_bk[cur]) * BWD));
      #4;
      checks++;
      if (s_ready !== x_sr || a_ready !== agnt) begin
        errors++;
        $display("FAIL rand_ready c=%0d got s=%b a=%b exp s=%b a=%b",
                 c, s_ready, a_ready, x_sr, agnt);
      end
      checks++;
      if (b_en !== x_en || b_addr !== x_ba) begin
        errors++;
        $display("FAIL rand_buf c=%0d got en=%b ad=%h exp en=%b ad=%h",
                 c, b_en, b_addr, x_en, x_ba);
      end
      checks++;
      if (s_dvalid !== x_sdv || s_data !== x_sd) begin
        errors++;
        $display("FAIL rand_sdata c=%0d got v=%b exp v=%b", c, s_dvalid, x_sdv);
      end
      checks++;
      if (a_rvalid !== x_arv || a_err !== x_aerr || a_rdata !== x_ard) begin
        errors++;
        $display("FAIL rand_axi c=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, a_rvalid, a_err, a_rdata, x_arv, x_aerr, x_ard);
      end
      checks++;
      if (ccount !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_count c=%0d got %0d exp %0d", c, ccount, m_cnt);
      end
      if (conf && !awin) begin
        m_wait++;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_wait = 0;
      end
      fut = (c + L) % 8;
      da_v[cur] = 0;
      for (int i = 0; i < N; i++) begin
        ds_v[cur][i] = 0;
        ds_v[fut][i] = x_sr[i];
        ds_lb[fut][i] = own[i];
      end
      da_v[fut] = agnt;
      da_err[fut] = (alb >= NLB);
      da_lb[fut] = alb;
      da_bk[fut] = abk;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    e_sv = 3'b001;
    e_aa = '0;
    e_av = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (e_cc !== 16'd65534) begin
      errors++;
      $display("FAIL sat_pre got %0d exp 65534", e_cc);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (e_cc !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_hold k=%0d got %h exp ffff", k, e_cc);
      end
    end
    e_sv = '0;
    e_av = 1'b0;
  endtask

  initial begin
    e_sv = '0; e_pp = '0; e_sa = '0;
    e_av = 1'b0; e_aa = '0; e_brd = '0;
    b_rdata = '0;
    test_reset();
    test_parallel();
    test_conflict();
    test_swap();
    test_oob();
    test_reset_inflight();
    test_random(600);
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
